// File: rtl/hamming_dec_ctrl.sv
// hamming_dec_ctrl: reads 16-bit SECDED codewords from memory, corrects single errors
// and writes back 11 data bits plus a 2-bit error flag. Four cycles per codeword.
// Latency: ack is raised 4*NWORDS edges after req is accepted in IDLE.
// Flow: level req starts a run. ack holds in DONE until req drops. No backpressure from memory.
// Optional build macro HAM_ERR_CNT_EN adds saturating single/double error counters.
module hamming_dec_ctrl #(
  parameter int AW       = 8,
  parameter int SRC_BASE = 64,
  parameter int DST_BASE = 94,
  parameter int NWORDS   = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  output logic          ack,
  output logic [AW-1:0] raddr,
  input  logic [7:0]    rdata,
  output logic [AW-1:0] waddr,
  output logic          write_en,
  output logic [7:0]    wdata
`ifdef HAM_ERR_CNT_EN
  ,
  output logic [7:0]    single_cnt,
  output logic [7:0]    double_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_LO = 3'd1,
    RD_HI = 3'd2,
    WR_LO = 3'd3,
    WR_HI = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [6:0]      index;
  logic [7:0]      lo_q;
  logic [7:0]      hi_q;
  logic            last;
  logic [AW-1:0]   word_off;

  logic [15:0]     cw;
  logic [15:0]     fixed;
  logic [3:0]      syn;
  logic            par;
  logic [1:0]      flag;
  logic [7:0]      out_lo;
  logic [7:0]      out_hi;

  assign last     = (index == 7'(NWORDS - 1));
  // Each codeword occupies two bytes; the offset wraps with the address width.
  assign word_off = AW'({index, 1'b0});

  // Decode the captured codeword: syndrome, overall parity, correction, output packing.
  always_comb begin
    cw   = {hi_q, lo_q};
    syn  = 4'd0;
    for (int i = 1; i < 16; i++) begin
      if (cw[i]) syn = syn ^ 4'(i);
    end
    par   = ^cw;
    fixed = cw;
    flag  = 2'b00;
    if (par) begin
      // Odd parity: a single flip at the syndrome position (0 means p0 itself).
      fixed[syn] = ~cw[syn];
      flag       = 2'b01;
    end else if (syn != 4'd0) begin
      // Even parity with a nonzero syndrome: uncorrectable, pass data through raw.
      flag = 2'b10;
    end
    out_lo = {fixed[12:9], fixed[7:5], fixed[3]};
    out_hi = {flag, 3'b000, fixed[15:13]};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state and Moore outputs; all memory strobes are idle outside the active states.
  always_comb begin
    next_state = state;
    ack        = 1'b0;
    raddr      = '0;
    waddr      = '0;
    write_en   = 1'b0;
    wdata      = 8'h00;
    case (state)
      IDLE: begin
        if (req) next_state = RD_LO;
      end
      RD_LO: begin
        raddr      = AW'(SRC_BASE) + word_off;
        next_state = RD_HI;
      end
      RD_HI: begin
        raddr      = AW'(SRC_BASE) + word_off + AW'(1);
        next_state = WR_LO;
      end
      WR_LO: begin
        write_en   = 1'b1;
        waddr      = AW'(DST_BASE) + word_off;
        wdata      = out_lo;
        next_state = WR_HI;
      end
      WR_HI: begin
        write_en   = 1'b1;
        waddr      = AW'(DST_BASE) + word_off + AW'(1);
        wdata      = out_hi;
        next_state = last ? DONE : RD_LO;
      end
      DONE: begin
        ack = 1'b1;
        if (!req) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Capture registers and word index; index is parked at zero outside a run.
  always_ff @(posedge clk) begin
    if (reset) begin
      index <= 7'd0;
      lo_q  <= 8'h00;
      hi_q  <= 8'h00;
    end else begin
      case (state)
        IDLE:    index <= 7'd0;
        RD_LO:   lo_q  <= rdata;
        RD_HI:   hi_q  <= rdata;
        WR_HI:   if (!last) index <= index + 7'd1;
        DONE:    index <= 7'd0;
        default: ;
      endcase
    end
  end

`ifdef HAM_ERR_CNT_EN
  // Per-run saturating error counters, cleared when a run starts and held through DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      single_cnt <= 8'd0;
      double_cnt <= 8'd0;
    end else if (state == IDLE && req) begin
      single_cnt <= 8'd0;
      double_cnt <= 8'd0;
    end else if (state == WR_HI) begin
      if (flag == 2'b01 && single_cnt != 8'hFF) single_cnt <= single_cnt + 8'd1;
      if (flag == 2'b10 && double_cnt != 8'hFF) double_cnt <= double_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hamming_dec_ctrl.sv
// Testbench for hamming_dec_ctrl: behavioural byte memory, search-based SECDED reference
// model feeding a write scoreboard, directed runs for clean, single, double, reset-abort
// and req-hold scenarios.
module tb_hamming_dec_ctrl;
  localparam int AW  = 8;
  localparam int SRC = 64;
  localparam int DST = 94;
  localparam int NW  = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          req;
  logic          ack;
  logic [AW-1:0] raddr;
  logic [7:0]    rdata;
  logic [AW-1:0] waddr;
  logic          write_en;
  logic [7:0]    wdata;
`ifdef HAM_ERR_CNT_EN
  logic [7:0]    single_cnt;
  logic [7:0]    double_cnt;
`endif

  logic          ld_en;
  logic [7:0]    ld_addr;
  logic [7:0]    ld_dat;
  logic [7:0]    mem [0:255];

  int            errors = 0;
  int            checks = 0;
  int            nwrites = 0;
  int            exp_single = 0;
  int            exp_double = 0;
  logic [15:0]   sb_q [$];
  logic [15:0]   cws [NW];

  hamming_dec_ctrl #(.AW(AW), .SRC_BASE(SRC), .DST_BASE(DST), .NWORDS(NW)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .ack      (ack),
    .raddr    (raddr),
    .rdata    (rdata),
    .waddr    (waddr),
    .write_en (write_en),
    .wdata    (wdata)
`ifdef HAM_ERR_CNT_EN
    ,
    .single_cnt (single_cnt),
    .double_cnt (double_cnt)
`endif
  );

  always #5 clk = ~clk;

  assign rdata = mem[raddr];

  always @(posedge clk) begin
    if (ld_en)         mem[ld_addr] <= ld_dat;
    else if (write_en) mem[waddr]   <= wdata;
  end

  // Reference encoder: place data bits, then build each parity bit from its coverage set.
  function automatic logic [15:0] encode(input logic [10:0] d);
    logic [15:0] w;
    int k;
    w = '0;
    k = 0;
    for (int i = 3; i < 16; i++) begin
      if ((i & (i - 1)) != 0) begin
        w[i] = d[k];
        k++;
      end
    end
    for (int b = 0; b < 4; b++) begin
      for (int i = 1; i < 16; i++) begin
        if (i[b] && i != (1 << b)) w[1 << b] = w[1 << b] ^ w[i];
      end
    end
    w[0] = ^w[15:1];
    return w;
  endfunction

  function automatic logic [10:0] extract(input logic [15:0] w);
    logic [10:0] d;
    int k;
    d = '0;
    k = 0;
    for (int i = 3; i < 16; i++) begin
      if ((i & (i - 1)) != 0) begin
        d[k] = w[i];
        k++;
      end
    end
    return d;
  endfunction

  // Reference decoder by search: valid codeword, else nearest codeword at distance one,
  // else uncorrectable. Returns {hi, lo} of the expected output word.
  function automatic logic [15:0] model(input logic [15:0] w);
    logic [15:0] c;
    logic [15:0] t;
    logic [1:0]  f;
    logic [10:0] d;
    c = w;
    f = 2'b10;
    if (encode(extract(w)) == w) begin
      f = 2'b00;
    end else begin
      for (int i = 0; i < 16; i++) begin
        t = w ^ (16'd1 << i);
        if (encode(extract(t)) == t) begin
          f = 2'b01;
          c = t;
        end
      end
    end
    d = extract(c);
    return {f, 3'b000, d[10:8], d[7:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write source codewords and poison the destination region so stale data shows up.
  task automatic load_mem();
    ld_en = 1'b1;
    for (int w = 0; w < NW; w++) begin
      ld_addr = 8'(SRC + 2 * w);     ld_dat = cws[w][7:0];  tick();
      ld_addr = 8'(SRC + 2 * w + 1); ld_dat = cws[w][15:8]; tick();
      ld_addr = 8'(DST + 2 * w);     ld_dat = 8'hAA;        tick();
      ld_addr = 8'(DST + 2 * w + 1); ld_dat = 8'hAA;        tick();
    end
    ld_en = 1'b0;
  endtask

  task automatic push_expected();
    logic [15:0] o;
    exp_single = 0;
    exp_double = 0;
    for (int w = 0; w < NW; w++) begin
      o = model(cws[w]);
      sb_q.push_back({8'(DST + 2 * w), o[7:0]});
      sb_q.push_back({8'(DST + 2 * w + 1), o[15:8]});
      if (o[15:14] == 2'b01) exp_single++;
      if (o[15:14] == 2'b10) exp_double++;
    end
  endtask

  // Sampled #1 after an edge: any active write commits on the following edge.
  task automatic observe();
    logic [15:0] e;
    if (write_en) begin
      nwrites++;
      check("write_expected", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("write_addr_data", {16'd0, waddr, wdata}, {16'd0, e});
      end
    end
  endtask

  // Edge 1 is the edge that samples req; returns the edge number on which ack is seen high.
  task automatic run_pass(input bit hold, output int n);
    req = 1'b1;
    n = 0;
    while (n < 400) begin
      tick();
      n++;
      if (!hold) req = 1'b0;
      observe();
      if (ack) break;
    end
    check("ack_latency", 32'(n), 32'(4 * NW + 1));
    check("sb_drained", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic randomize_cws();
    for (int w = 0; w < NW; w++) cws[w] = 16'($urandom);
  endtask

  initial begin
    int n;
    int bad_we;
    int bad_ack;
    reset   = 1'b1;
    req     = 1'b0;
    ld_en   = 1'b0;
    ld_addr = 8'h00;
    ld_dat  = 8'h00;
    repeat (3) tick();
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_write_en", 32'(write_en), 32'd0);
    check("rst_raddr", 32'(raddr), 32'd0);
    check("rst_waddr", 32'(waddr), 32'd0);
    check("rst_wdata", 32'(wdata), 32'd0);
`ifdef HAM_ERR_CNT_EN
    check("rst_single_cnt", 32'(single_cnt), 32'd0);
    check("rst_double_cnt", 32'(double_cnt), 32'd0);
`endif
    reset = 1'b0;
    tick();

    // All-zero codewords with a single-cycle req pulse.
    for (int w = 0; w < NW; w++) cws[w] = 16'h0000;
    load_mem();
    push_expected();
    run_pass(1'b0, n);
    tick();
    check("idle_ack_low", 32'(ack), 32'd0);
    for (int a = DST; a < DST + 2 * NW; a++) check("zero_dst", 32'(mem[a]), 32'd0);

    // Single flipped data bit.
    randomize_cws();
    cws[0] = 16'h0020;
    load_mem();
    push_expected();
    run_pass(1'b0, n);
    tick();
    check("single_lo", 32'(mem[94]), 32'h00);
    check("single_hi", 32'(mem[95]), 32'h40);
`ifdef HAM_ERR_CNT_EN
    check("single_cnt", 32'(single_cnt), 32'(exp_single));
`endif

    // Double error: data passed through uncorrected.
    randomize_cws();
    cws[0] = 16'h0028;
    load_mem();
    push_expected();
    run_pass(1'b0, n);
    tick();
    check("double_lo", 32'(mem[94]), 32'h03);
    check("double_hi", 32'(mem[95]), 32'h80);
`ifdef HAM_ERR_CNT_EN
    check("double_cnt", 32'(double_cnt), 32'(exp_double));
`endif

    // p0 flipped, and the all-ones valid codeword.
    randomize_cws();
    cws[0] = 16'h0001;
    cws[1] = 16'hFFFF;
    load_mem();
    push_expected();
    run_pass(1'b0, n);
    tick();
    check("p0_lo", 32'(mem[94]), 32'h00);
    check("p0_hi", 32'(mem[95]), 32'h40);
    check("ones_lo", 32'(mem[96]), 32'hFF);
    check("ones_hi", 32'(mem[97]), 32'h07);

    // Reset during the WR_HI that follows the third WR_LO.
    randomize_cws();
    load_mem();
    push_expected();
    nwrites = 0;
    req = 1'b1;
    n = 0;
    while (nwrites < 6 && n < 100) begin
      tick();
      n++;
      req = 1'b0;
      observe();
    end
    check("abort_reached", 32'(nwrites), 32'd6);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_write_en", 32'(write_en), 32'd0);
    check("abort_ack", 32'(ack), 32'd0);
    check("abort_raddr", 32'(raddr), 32'd0);
    bad_we  = 0;
    bad_ack = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (write_en !== 1'b0) bad_we++;
      if (ack !== 1'b0) bad_ack++;
    end
    check("abort_no_writes", 32'(bad_we), 32'd0);
    check("abort_no_ack", 32'(bad_ack), 32'd0);
    sb_q.delete();
    randomize_cws();
    load_mem();
    push_expected();
    run_pass(1'b0, n);
    tick();

    // req held high through DONE must not start a second pass.
    randomize_cws();
    load_mem();
    push_expected();
    run_pass(1'b1, n);
    bad_we  = 0;
    bad_ack = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (write_en !== 1'b0) bad_we++;
      if (ack !== 1'b1) bad_ack++;
    end
    check("hold_no_rerun", 32'(bad_we), 32'd0);
    check("hold_ack_high", 32'(bad_ack), 32'd0);
`ifdef HAM_ERR_CNT_EN
    check("hold_single_cnt", 32'(single_cnt), 32'(exp_single));
    check("hold_double_cnt", 32'(double_cnt), 32'(exp_double));
`endif
    req = 1'b0;
    tick();
    check("ack_drop", 32'(ack), 32'd0);
    push_expected();
    run_pass(1'b0, n);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
